serial_rx_fifo: RTL and testbench

//  UART receiver for the AVR serial link (the AVR->FPGA direction; the debug transmitter drives the other direction).

---
 rtl/serial_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_serial_rx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// 8N1 UART receiver for the AVR->FPGA link with a small FWFT receive FIFO.
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module serial_rx_fifo #(
    parameter int CLK_PER_BIT = 434,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    logic          rx_m, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          push, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, pop, wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // A pop frees the slot the full-FIFO push overwrites in the same cycle
    assign full  = (count == FULL);
    assign valid = (count != '0);
    assign pop   = valid && ready;
    assign wr    = push && (!full || pop);
    assign data  = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= sh;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            frame_err <= ferr;
            overflow  <= push && full && !pop;
        end
    end
endmodule

// File: tb/tb_serial_rx_fifo.sv
// Scoreboard bench for serial_rx_fifo: stimulus queues expected bytes,
// a negedge monitor pops and compares whatever the DUT hands out.
module tb_serial_rx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       frame_err;
    logic       overflow;

    serial_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .count(count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
    logic [7:0] exp_q[$];
    bit rand_ready = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard
    logic pv = 0, pr = 0, prst = 1;
    logic [7:0] pd = 0;
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {18'd0, data, valid, count, frame_err, overflow}, 32'd0);
        end else begin
            if (frame_err) fe_seen++;
            if (overflow) ov_seen++;
            if (pv && !pr && !prst) begin
                check("hold_valid", valid, 1);
                check("hold_data", data, pd);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %02h expected none", data);
                end else begin
                    check("rx_data", data, exp_q.pop_front());
                end
            end
        end
        pv = valid; pr = ready; pd = data; prst = rst;
    end

    task automatic wait_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(logic [9:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic send_frame(logic [7:0] b, logic stop = 1'b1);
        send_bits({stop, b, 1'b0}, 10);
    endtask

    task automatic idle(int nbits);
        rx = 1'b1;
        wait_cycles(nbits * CPB);
    endtask

    task automatic drain(string nm);
        ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            wait_cycles(1);
        end
        wait_cycles(2);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
        check({nm, "_valid0"}, valid, 0);
        check({nm, "_count0"}, count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [7:0] b;
        int r;

        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        check("post_reset_valid", valid, 0);
        check("post_reset_count", count, 0);
        ready = 1'b1;
        idle(1);

        // Single clean frame: latency and count behaviour
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5);
            begin
                lat = -1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (valid) begin
                        lat = i;
                        break;
                    end
                end
                check("t1_latency", lat, 155);
                check("t1_count1", count, 1);
                @(negedge clk);
                check("t1_count0", count, 0);
                check("t1_valid0", valid, 0);
            end
        join
        idle(1);
        check("t1_no_flags", fe_seen + ov_seen, 0);

        // Stop bit low, line held low, then a clean byte
        send_frame(8'h3C, 1'b0);
        wait_cycles(3 * CPB);
        fe_exp++;
        idle(1);
        check("t2_ferr", fe_seen, fe_exp);
        exp_q.push_back(8'h55);
        send_frame(8'h55);
        idle(1);
        check("t2_ferr_once", fe_seen, fe_exp);
        check("t2_queue", exp_q.size(), 0);

        // Short glitch is ignored
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(40);
        check("t3_valid0", valid, 0);
        check("t3_no_ferr", fe_seen, fe_exp);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A);
        idle(1);
        check("t3_after_glitch", exp_q.size(), 0);

        // Fill and overflow
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i));
        end
        ov_exp++;
        idle(1);
        check("t4_count_full", count, 4);
        check("t4_overflow", ov_seen, ov_exp);
        drain("t4");

        // Full FIFO with a pop on the stop-sample cycle
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i));
        end
        exp_q.push_back(8'h06);
        fork
            send_frame(8'h06);
            begin
                wait_cycles(154);
                ready = 1'b1;
                wait_cycles(1);
                ready = 1'b0;
            end
        join
        idle(1);
        check("t5_count_full", count, 4);
        check("t5_no_overflow", ov_seen, ov_exp);
        drain("t5");

        // Reset in mid-frame
        send_bits({1'b1, 8'h7E, 1'b0}, 5);
        rst = 1'b1;
        wait_cycles(3);
        check("t6_in_reset", {data, valid, count}, 0);
        rx = 1'b1;
        rst = 1'b0;
        idle(1);
        exp_q.push_back(8'h81);
        send_frame(8'h81);
        idle(1);
        check("t6_only_81", exp_q.size(), 0);
        check("t6_count0", count, 0);

        // Randomised traffic with random back-pressure
        rand_ready = 1;
        fork
            while (rand_ready) begin
                wait_cycles(1);
                ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 7);
            b = 8'($urandom);
            if (r == 0) begin
                send_frame(b, 1'b0);
                wait_cycles($urandom_range(1, 40));
                fe_exp++;
                idle(1);
            end else if (r == 1) begin
                rx = 1'b0;
                wait_cycles($urandom_range(1, 6));
                idle(1);
            end else begin
                exp_q.push_back(b);
                send_frame(b);
                idle($urandom_range(0, 2));
            end
        end
        rand_ready = 0;
        wait_cycles(3);
        drain("rand");
        check("final_ferr", fe_seen, fe_exp);
        check("final_overflow", ov_seen, ov_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
